// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Front end of the FFT sample cache. Takes a valid/ready stream of 16-bit
//   samples and writes one frame of 2**LOG2N samples into the cache at
//   bit-reversed addresses, so the butterflies can work in place.
//
//   The cache registers write_adr one edge before it uses it, but uses
//   data_in/write directly. The address is therefore launched on the transfer
//   edge, and data/enable one edge later. The cache stores the sample on the
//   edge after that.
//
// Parameters
//   LOG2N     log2 of the frame length, 1..12
//   BASE_ADR  cache address of sample slot 0 (BASE_ADR + 2**LOG2N <= 4096)
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous reset, active low
//   start       begin a new frame; ignored unless the loader is idle
//   s_data      input sample
//   s_valid     s_data is valid
//   s_ready     the loader accepts s_data this cycle
//   data_in     cache write data
//   write_adr   cache write address, one cycle ahead of data_in/write
//   write       cache write enable
//   busy        high from the accepted start until frame_done
//   frame_done  one-cycle pulse once the whole frame is in the cache
//   sample_cnt  samples accepted in the current frame
//
// State table
//   IDLE   | waiting for start
//   LOAD   | accepting samples, s_ready high
//   FLUSH1 | last sample accepted, its address is in the cache skew register
//   FLUSH2 | last sample on data_in/write, stored at the end of this cycle
//   DONE   | frame_done high for one cycle; start is not yet honoured

module fft_input_loader #(
    parameter int LOG2N    = 10,
    parameter int BASE_ADR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] data_in,
    output logic [11:0] write_adr,
    output logic        write,
    output logic        busy,
    output logic        frame_done,
    output logic [11:0] sample_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH1 = 3'd2,
        FLUSH2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [12:0] LAST_IDX = 13'((1 << LOG2N) - 1);

    state_t      state;
    state_t      next_state;
    logic [12:0] cnt;
    logic [15:0] stage_data;
    logic        stage_valid;
    logic        transfer;
    logic        start_ok;
    logic [11:0] rev;
    logic [11:0] next_adr;

    assign s_ready    = (state == LOAD);
    assign transfer   = s_valid & s_ready;
    assign start_ok   = start & (state == IDLE);
    // With LOG2N=12 the full count (4096) wraps to 0 on this 12-bit port.
    assign sample_cnt = cnt[11:0];

    // Bit-reverse the low LOG2N bits of the sample index.
    always_comb begin
        rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rev[i] = cnt[LOG2N-1-i];
        end
        next_adr = 12'(BASE_ADR) + rev;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (transfer && cnt == LAST_IDX) next_state = FLUSH1;
            FLUSH1:  next_state = FLUSH2;
            FLUSH2:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            write_adr   <= '0;
            stage_data  <= '0;
            stage_valid <= 1'b0;
            data_in     <= '0;
            write       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state <= next_state;

            if (start_ok) begin
                cnt <= '0;
            end else if (transfer) begin
                cnt <= cnt + 13'd1;
            end

            // Address leads data by one edge to match the cache's address register.
            if (transfer) begin
                write_adr  <= next_adr;
                stage_data <= s_data;
            end
            stage_valid <= transfer;

            if (stage_valid) begin
                data_in <= stage_data;
            end
            write <= stage_valid;

            // The last sample is stored on the edge that leaves FLUSH2.
            if (start_ok) begin
                busy <= 1'b1;
            end else if (state == FLUSH2) begin
                busy <= 1'b0;
            end
            frame_done <= (state == FLUSH2);
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        start   = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data  = 16'h0;
    logic        rst_n_v [3];

    logic        rdy  [3];
    logic        wr   [3];
    logic        bsy  [3];
    logic        fd   [3];
    logic [15:0] din  [3];
    logic [11:0] wadr [3];
    logic [11:0] scnt [3];

    fft_input_loader #(.LOG2N(3), .BASE_ADR(0)) u_n8 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[0]), .data_in(din[0]), .write_adr(wadr[0]), .write(wr[0]),
        .busy(bsy[0]), .frame_done(fd[0]), .sample_cnt(scnt[0]));

    fft_input_loader #(.LOG2N(2), .BASE_ADR(2048)) u_n4 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[1]), .data_in(din[1]), .write_adr(wadr[1]), .write(wr[1]),
        .busy(bsy[1]), .frame_done(fd[1]), .sample_cnt(scnt[1]));

    fft_input_loader #(.LOG2N(12), .BASE_ADR(0)) u_n4096 (
        .clk(clk), .rst_n(rst_n_v[2]), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy[2]), .data_in(din[2]), .write_adr(wadr[2]), .write(wr[2]),
        .busy(bsy[2]), .frame_done(fd[2]), .sample_cnt(scnt[2]));

    int cur = 0;
    int n_log = 3;
    int base = 0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem  [4096];
    logic [15:0] sent [4096];
    int adr_reg = 0;

    int dut_busy_cycles = 0;
    int dut_fd_pulses = 0;

    // Behavioural model: event-based view of a frame.
    bit          m_loading = 0;
    bit          m_busy = 0;
    bit          m_fd = 0;
    bit          m_write = 0;
    bit          m_xfer = 0;
    bit          m_rst = 1;
    bit          m_idle = 0;
    bit          pend_valid = 0;
    logic [15:0] pend_data = 0;
    logic [15:0] m_data = 0;
    int          m_cnt = 0;
    int          m_fd_cd = 0;
    int          m_addr = 0;
    bit          in_rst, in_st, in_v;
    logic [15:0] in_d;

    function automatic int bitrev(int k, int nb);
        int r = 0;
        for (int i = 0; i < nb; i++) begin
            if (k[i]) r = r | (1 << (nb - 1 - i));
        end
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Cache model: address registered one edge before the write uses it.
    always @(negedge clk) begin
        if (wr[cur]) mem[adr_reg] = din[cur];
        adr_reg = int'(wadr[cur]);
    end

    always @(posedge clk) begin
        in_rst = rst_n_v[cur];
        in_st  = start;
        in_v   = s_valid;
        in_d   = s_data;
        if (!in_rst) begin
            m_loading = 0; m_busy = 0; m_fd = 0; m_write = 0; m_xfer = 0;
            m_cnt = 0; m_fd_cd = 0; pend_valid = 0; m_data = 16'h0; m_rst = 1;
        end else begin
            m_rst  = 0;
            m_idle = !m_busy && !m_fd;
            m_xfer = m_loading && in_v;
            // Sample accepted one edge ago appears on data_in/write now.
            m_write = pend_valid;
            if (pend_valid) m_data = pend_data;
            pend_valid = m_xfer;
            pend_data  = in_d;
            m_fd = 0;
            if (m_fd_cd > 0) begin
                m_fd_cd--;
                if (m_fd_cd == 0) begin
                    m_fd = 1;
                    m_busy = 0;
                end
            end
            if (in_st && m_idle) begin
                m_busy = 1; m_loading = 1; m_cnt = 0;
            end
            if (m_xfer) begin
                m_addr = base + bitrev(m_cnt, n_log);
                m_cnt++;
                if (m_cnt == (1 << n_log)) begin
                    m_loading = 0;
                    m_fd_cd = 2;
                end
            end
        end
        #1;
        check("s_ready", int'(rdy[cur]), int'(m_loading));
        check("busy", int'(bsy[cur]), int'(m_busy));
        check("frame_done", int'(fd[cur]), int'(m_fd));
        check("sample_cnt", int'(scnt[cur]), m_cnt & 'hFFF);
        check("write", int'(wr[cur]), int'(m_write));
        if (m_write) check("data_in", int'(din[cur]), int'(m_data));
        if (m_xfer)  check("write_adr", int'(wadr[cur]), m_addr);
        if (m_rst) begin
            check("rst_data_in", int'(din[cur]), 0);
            check("rst_write_adr", int'(wadr[cur]), 0);
        end
        if (bsy[cur]) dut_busy_cycles++;
        if (fd[cur]) dut_fd_pulses++;
    end

    task automatic cyc(bit st, bit v, logic [15:0] d);
        @(negedge clk);
        start = st; s_valid = v; s_data = d;
    endtask

    task automatic select(int i, int nl, int b);
        @(negedge clk);
        for (int j = 0; j < 3; j++) rst_n_v[j] = 1'b0;
        start = 0; s_valid = 0;
        cur = i; n_log = nl; base = b;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 4096; a++) mem[a] = 16'hDEAD;
        rst_n_v[i] = 1'b1;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
    task automatic stream(int cnt, int mode, bit noise);
        int   k = 0;
        int   guard = 0;
        logic v;
        while (k < cnt && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = guard[0];
            else                v = 1'($urandom_range(0, 1));
            start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            s_valid = v;
            s_data  = v ? sent[k] : 16'($urandom);
            if (v && rdy[cur]) k++;
        end
        if (k < cnt) check("stream_timeout", k, cnt);
    endtask

    task automatic wait_done(bit noise);
        int g = 0;
        while (!fd[cur] && g < 50) begin
            @(negedge clk);
            start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 16'($urandom);
            g++;
        end
        check("frame_done_seen", int'(fd[cur]), 1);
        repeat (3) cyc(0, 0, 16'h0);
    endtask

    task automatic frame(int mode, bit noise, int lead);
        cyc(1, 0, 16'h0);
        repeat (lead) cyc(0, 0, 16'h0);
        stream(1 << n_log, mode, noise);
        wait_done(noise);
    endtask

    task automatic mem_check(string name);
        int errs = 0;
        for (int k = 0; k < (1 << n_log); k++) begin
            if (mem[base + bitrev(k, n_log)] !== sent[k]) errs++;
        end
        check(name, errs, 0);
    endtask

    initial begin
        for (int j = 0; j < 3; j++) rst_n_v[j] = 1'b0;
        for (int a = 0; a < 4096; a++) begin
            mem[a] = 16'hDEAD;
            sent[a] = 16'h0;
        end

        // Frame of 8 at base 0, back-to-back; s_valid in IDLE must be ignored.
        select(0, 3, 0);
        repeat (4) cyc(0, 1, 16'h5555);
        for (int k = 0; k < 8; k++) sent[k] = 16'h1000 + 16'(k);
        frame(0, 0, 0);
        mem_check("mem_b2b");
        check("lit_mem0", int'(mem[0]), 'h1000);
        check("lit_mem4", int'(mem[4]), 'h1001);
        check("lit_mem6", int'(mem[6]), 'h1003);
        check("lit_mem1", int'(mem[1]), 'h1004);
        check("lit_mem3", int'(mem[3]), 'h1006);

        // Same frame with a gap every other cycle.
        for (int a = 0; a < 16; a++) mem[a] = 16'hDEAD;
        frame(1, 0, 0);
        mem_check("mem_gaps");
        check("lit_gap_mem5", int'(mem[5]), 'h1005);

        // Random data, random valid, stray start pulses throughout.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) sent[k] = 16'($urandom);
            frame(2, 1, 0);
            mem_check("mem_random");
        end

        // Reset after 5 of 8 samples, then a clean full frame.
        for (int k = 0; k < 8; k++) sent[k] = 16'h2000 + 16'(k);
        cyc(1, 0, 16'h0);
        stream(5, 0, 0);
        @(negedge clk);
        rst_n_v[0] = 1'b0;
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        s_valid = 1'b0;
        repeat (3) cyc(0, 1, 16'h7777);
        for (int a = 0; a < 16; a++) mem[a] = 16'hDEAD;
        for (int k = 0; k < 8; k++) sent[k] = 16'h3000 + 16'(k);
        frame(0, 0, 0);
        mem_check("mem_after_reset");

        // Frame of 4 at base 2048.
        select(1, 2, 2048);
        for (int k = 0; k < 4; k++) sent[k] = 16'hA + 16'(k);
        frame(0, 0, 0);
        mem_check("mem_base2048");
        check("lit_mem2048", int'(mem[2048]), 'hA);
        check("lit_mem2050", int'(mem[2050]), 'hB);
        check("lit_mem2049", int'(mem[2049]), 'hC);
        check("lit_mem2051", int'(mem[2051]), 'hD);

        // Full 4096-sample frame, value = index; stream starts two edges after start.
        select(2, 12, 0);
        for (int k = 0; k < 4096; k++) sent[k] = 16'(k);
        dut_busy_cycles = 0;
        dut_fd_pulses = 0;
        frame(0, 0, 1);
        mem_check("mem_4096");
        check("lit_mem_bitrev1", int'(mem[2048]), 1);
        check("lit_mem_bitrev3", int'(mem[3072]), 3);
        check("busy_cycles_4096", dut_busy_cycles, 4099);
        check("frame_done_pulses", dut_fd_pulses, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
